stage_b: RTL

STAGE_B -- requirements
Module: stage_B

---
 rtl/stage_b.sv | 120 ++++++++++++
 1 files changed

// File: rtl/stage_b.sv
// stage_b: elastic handshake stage. Captures words from an upstream
// DIR/ack_prev handshake into a small FIFO, then presents each word plus
// STEP on a DOR/ack_from_next handshake to the downstream stage.
//
// Ports
//   clk            only clock, rising edge
//   reset          synchronous, active high
//   DIR            upstream data-in-ready (held until ack_prev seen)
//   data_in        upstream word, valid while DIR=1
//   ack_prev       one-cycle registered acknowledge to upstream
//   DOR            registered data-out-ready to downstream
//   data_out       registered output word (head + STEP, mod 256)
//   ack_from_next  downstream acknowledge
//   level          FIFO occupancy, 0..DEPTH
module stage_b #(
  parameter int         DEPTH   = 4,
  parameter logic [7:0] STEP    = 8'd2,
  parameter logic [1:0] IDLE    = 2'd0,
  parameter logic [1:0] PRESENT = 2'd1,
  parameter logic [1:0] RELEASE = 2'd2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     DIR,
  input  logic [7:0]               data_in,
  output logic                     ack_prev,
  output logic                     DOR,
  output logic [7:0]               data_out,
  input  logic                     ack_from_next,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_PRESENT = PRESENT,
    ST_RELEASE = RELEASE
  } state_e;

  // Control state starts at its reset values so power-up matches reset.
  state_e        state_q  = ST_IDLE;
  logic          ack_q    = 1'b0;
  logic          dor_q    = 1'b0;
  logic [7:0]    dout_q   = 8'd0;
  logic [LW-1:0] level_q  = '0;
  logic [AW-1:0] wr_ptr_q = '0;
  logic [AW-1:0] rd_ptr_q = '0;
  logic [LW-1:0] level_d;
  logic [7:0]    mem_q [DEPTH];

  logic push, pop;

  // Cooldown: while ack_prev is high, upstream may still be holding DIR for
  // the word just taken, so DIR is ignored. Full is judged on the registered
  // level only; a same-cycle pop does not open a slot.
  assign push = DIR && !ack_q && (level_q < FULL);
  assign pop  = (state_q == ST_IDLE) && (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset; contents are meaningless until written.
  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      dor_q    <= 1'b0;
      dout_q   <= 8'd0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q <= level_d;
      ack_q   <= push;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            dout_q   <= mem_q[rd_ptr_q] + STEP;  // 8-bit, carry dropped
            dor_q    <= 1'b1;
            rd_ptr_q <= rd_ptr_q + AW'(1);
            state_q  <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack_from_next) begin
            dor_q   <= 1'b0;
            state_q <= ST_RELEASE;
          end
        end
        // One dead cycle so a lingering ack is not taken for the next word.
        ST_RELEASE: state_q <= ST_IDLE;
        default: begin
          dor_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_prev = ack_q;
  assign DOR      = dor_q;
  assign data_out = dout_q;
  assign level    = level_q;

endmodule
